core_run_sequencer: RTL and testbench
=====================================

Name: core_run_sequencer

Overview:
Sits directly upstream of the multicycle RISC-V core. It owns the core's reset and run inputs, starts a program run from a board button, and waits for the core's done. It then captures the core's register3, PC and run-cycle count into stable result registers for LEDs and 7-segment display logic. An optional watchdog aborts runs that never assert done.

Parameters:
CYCLE_W, 16, width of run-cycle counter and result
CORE_RST_CYCLES, 4, cycles core_reset is held high per run (>=1)
TIMEOUT, 4095, watchdog limit in WAIT_DONE cycles (< 2**CYCLE_W); used only with watchdog compiled in

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
start_btn  in  1  raw, asynchronous start button
core_done  in  1  core done flag
core_reg3  in  32  core register3 value
core_pc  in  32  core PC value
core_reset  out  1  reset to core
core_run  out  1  run to core
result_reg3  out  32  captured register3
result_pc  out  32  captured PC
run_cycles  out  CYCLE_W  captured cycle count
result_valid  out  1  capture registers hold a completed run
busy  out  1  high in CORE_RST, START, WAIT_DONE, CAPTURE
timeout_flag  out  1  last run aborted by watchdog
seq_state  out  3  current state encoding, for debug LEDs

Behaviour:
- Reset (async, any state, mid-run included): state IDLE; core_reset=1, core_run=0, result_* =0, run_cycles=0, result_valid=0, timeout_flag=0, busy=0, sync flops=0, counters=0.
- Start detect: start_btn -> 2-flop synchronizer -> prev flop. start_pulse = sync2 & ~prev.
  - FSM is in CORE_RST after the 3rd rising edge following start_btn rising.
  - A held button yields exactly one pulse.
  - Pulses outside IDLE/HOLD/ERROR are ignored.
- States (encoding): IDLE=0, CORE_RST=1, START=2, WAIT_DONE=3, CAPTURE=4, HOLD=5, ERROR=6.
- IDLE: core_reset=1, core_run=0. start_pulse -> CORE_RST.
- CORE_RST: core_reset=1, core_run=0.
  - On entry: rst counter=0, cycle counter=0, result_valid=0, timeout_flag=0.
  - Stays exactly CORE_RST_CYCLES cycles, then -> START.
- START: core_reset=0, core_run=1, for one cycle. core_done is ignored here. -> WAIT_DONE.
- WAIT_DONE: core_reset=0, core_run=1.
  - Cycle where core_done=0: counter increments, saturating at 2**CYCLE_W-1.
  - Cycle where core_done=1: -> CAPTURE; counter is not incremented.
- CAPTURE (1 cycle): core_run=0.
  - result_reg3<=core_reg3, result_pc<=core_pc, run_cycles<=counter, result_valid<=1.
  - -> HOLD.
- HOLD: core_reset=0, core_run=0. Core is frozen and results are stable. start_pulse -> CORE_RST.
- ERROR: core_reset=1, core_run=0, timeout_flag=1, result_valid=0. start_pulse -> CORE_RST.
- Result registers change only in CAPTURE and on reset. They keep the old value through CORE_RST; only result_valid drops.
- Unused encoding 7 -> IDLE.
- All outputs are registered or decoded from the state register only; no combinational path from core_done to outputs.

Optional Feature:
CORE_WATCHDOG_EN
- Defined:
  - In WAIT_DONE, if counter==TIMEOUT and core_done=0 -> ERROR.
  - If core_done=1 in the same cycle, done wins -> CAPTURE.
- Undefined:
  - ERROR is unreachable (decode kept, maps to IDLE).
  - timeout_flag tied 0; counter only saturates.

Decomposition:
- Package core_seq_pkg:
  - state localparams (3-bit encodings above)
  - SEQ_STATE_W=3
  - default widths/limits for CYCLE_W, CORE_RST_CYCLES, TIMEOUT
- Sub-module btn_sync_edge:
  - 2-flop synchronizer + rising-edge detector
  - ports clock, reset, din, pulse
  - reusable for other board buttons

Test Plan:
(CORE_RST_CYCLES=4, TIMEOUT=100, CYCLE_W=16)
- Reset release, no button -> IDLE; core_reset=1, core_run=0, all results 0, seq_state=0.
- start_btn high 10 cycles; model core_done=1 on the 37th WAIT_DONE cycle, core_reg3=0x0000002A, core_pc=0x00000044 -> core_reset high exactly 4 CORE_RST cycles; run_cycles=36, result_reg3=0x2A, result_pc=0x44, result_valid=1, HOLD; only one run started.
- Second button press in HOLD -> result_valid drops in CORE_RST with old result_reg3 retained; new values captured at next done.
- Button pulses during WAIT_DONE -> ignored; state, counter and core_run unaffected.
- With CORE_WATCHDOG_EN, core_done stuck 0 -> ERROR after counter reaches 100; timeout_flag=1, core_reset=1. Done asserted on the counter==100 cycle -> CAPTURE, run_cycles=100, timeout_flag=0. Without the macro, stuck done -> remains in WAIT_DONE; counter saturates at 0xFFFF.
- Async reset asserted mid-WAIT_DONE (between clock edges) -> immediately core_reset=1, core_run=0, busy=0, IDLE; no capture occurs.

Source files
------------

// File: rtl/core_seq_pkg.sv
// core_seq_pkg
// Shared definitions for the core run sequencer: state encodings, default
// parameter values and the state-to-drive decode used to register the
// sequencer outputs alongside the state.
// Optional build macro used by the sequencer: CORE_WATCHDOG_EN.
package core_seq_pkg;

  localparam int SEQ_STATE_W         = 3;
  localparam int DEF_CYCLE_W         = 16;
  localparam int DEF_CORE_RST_CYCLES = 4;
  localparam int DEF_TIMEOUT         = 4095;

  // Encodings are visible on the debug LEDs, so they are fixed explicitly.
  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_CORE_RST  = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_HOLD      = 3'd5,
    ST_ERROR     = 3'd6
  } seq_state_e;

  // Drive pattern {core_reset, core_run, busy} for a given state.
  function automatic logic [2:0] seq_drive(input seq_state_e st);
    logic [2:0] d;
    case (st)
      ST_IDLE:      d = 3'b100;
      ST_CORE_RST:  d = 3'b101;
      ST_START:     d = 3'b011;
      ST_WAIT_DONE: d = 3'b011;
      ST_CAPTURE:   d = 3'b001;
      ST_HOLD:      d = 3'b000;
      ST_ERROR:     d = 3'b100;
      default:      d = 3'b100;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/core_run_sequencer_btn_sync_edge.sv
// btn_sync_edge
// Two-flop synchronizer followed by a rising-edge detector for a raw board
// button. pulse is high for exactly one clock per button press.
// Ports: clock (rising edge), reset (async, active-high), din (raw input),
//        pulse (one-cycle rising-edge pulse).
module btn_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronizer chain plus the delayed copy used for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/core_run_sequencer.sv
// core_run_sequencer
// Owns the reset/run inputs of the multicycle core. A button press resets
// the core for CORE_RST_CYCLES clocks, releases it, counts cycles until the
// core raises done, then captures register3, PC and the cycle count into
// stable result registers for the display logic.
// Build macro: CORE_WATCHDOG_EN -- when defined, a run whose cycle counter
// reaches TIMEOUT without done is aborted into ERROR with timeout_flag set.
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   start_btn             raw start button
//   core_done/reg3/pc     status from the core
//   core_reset, core_run  control to the core
//   result_reg3/pc        captured values, run_cycles captured count
//   result_valid          results belong to a completed run
//   busy, timeout_flag    status; seq_state current state for debug LEDs
module core_run_sequencer
  import core_seq_pkg::*;
#(
  parameter int CYCLE_W         = DEF_CYCLE_W,
  parameter int CORE_RST_CYCLES = DEF_CORE_RST_CYCLES,
  parameter int TIMEOUT         = DEF_TIMEOUT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               core_done,
  input  logic [31:0]        core_reg3,
  input  logic [31:0]        core_pc,
  output logic               core_reset,
  output logic               core_run,
  output logic [31:0]        result_reg3,
  output logic [31:0]        result_pc,
  output logic [CYCLE_W-1:0] run_cycles,
  output logic               result_valid,
  output logic               busy,
  output logic               timeout_flag,
  output logic [2:0]         seq_state
);

`ifdef CORE_WATCHDOG_EN
  localparam logic WD_EN = 1'b1;
`else
  localparam logic WD_EN = 1'b0;
`endif

  localparam int                 RST_W     = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES) : 1;
  localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(CORE_RST_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] CNT_MAX   = {CYCLE_W{1'b1}};
  localparam logic [CYCLE_W-1:0] TIMEOUT_C = CYCLE_W'(TIMEOUT);

  seq_state_e         state;
  logic [RST_W-1:0]   rst_cnt;
  logic [CYCLE_W-1:0] counter;
  logic               start_pulse;
  logic               can_start;

  btn_sync_edge u_start_sync (
    .clock (clock),
    .reset (reset),
    .din   (start_btn),
    .pulse (start_pulse)
  );

  // A new run may only be launched from a resting state.
  assign can_start = (state == ST_IDLE) || (state == ST_HOLD) || (state == ST_ERROR);
  assign seq_state = state;

  // Sequencer FSM; core controls and busy are registered together with the
  // state so no input can reach an output combinationally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      {core_reset, core_run, busy} <= seq_drive(ST_IDLE);
      rst_cnt      <= '0;
      counter      <= '0;
      result_reg3  <= 32'd0;
      result_pc    <= 32'd0;
      run_cycles   <= '0;
      result_valid <= 1'b0;
      timeout_flag <= 1'b0;
    end else if (start_pulse && can_start) begin
      state        <= ST_CORE_RST;
      {core_reset, core_run, busy} <= seq_drive(ST_CORE_RST);
      rst_cnt      <= '0;
      counter      <= '0;
      result_valid <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_IDLE;
        end
        ST_CORE_RST: begin
          if (rst_cnt == RST_LAST) begin
            state <= ST_START;
            {core_reset, core_run, busy} <= seq_drive(ST_START);
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        ST_START: begin
          // core_done is deliberately ignored for this first released cycle.
          state <= ST_WAIT_DONE;
          {core_reset, core_run, busy} <= seq_drive(ST_WAIT_DONE);
        end
        ST_WAIT_DONE: begin
          // done takes priority over the watchdog on the same cycle.
          if (core_done) begin
            state <= ST_CAPTURE;
            {core_reset, core_run, busy} <= seq_drive(ST_CAPTURE);
          end else if (WD_EN && (counter == TIMEOUT_C)) begin
            state        <= ST_ERROR;
            {core_reset, core_run, busy} <= seq_drive(ST_ERROR);
            timeout_flag <= WD_EN;
            result_valid <= 1'b0;
          end else if (counter != CNT_MAX) begin
            counter <= counter + 1'b1;
          end
        end
        ST_CAPTURE: begin
          result_reg3  <= core_reg3;
          result_pc    <= core_pc;
          run_cycles   <= counter;
          result_valid <= 1'b1;
          state        <= ST_HOLD;
          {core_reset, core_run, busy} <= seq_drive(ST_HOLD);
        end
        ST_HOLD: begin
          state <= ST_HOLD;
        end
        ST_ERROR: begin
          state <= ST_ERROR;
        end
        default: begin
          state <= ST_IDLE;
          {core_reset, core_run, busy} <= seq_drive(ST_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_sequencer.sv
// Directed bench for core_run_sequencer with an expected-result queue.
module tb_core_run_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_btn;
  logic        core_done;
  logic [31:0] core_reg3;
  logic [31:0] core_pc;
  logic        core_reset;
  logic        core_run;
  logic [31:0] result_reg3;
  logic [31:0] result_pc;
  logic [15:0] run_cycles;
  logic        result_valid;
  logic        busy;
  logic        timeout_flag;
  logic [2:0]  seq_state;

  typedef struct {
    logic [31:0] reg3;
    logic [31:0] pc;
    logic [15:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_rst;
  int          n_start;
  int          run_bad;
  int          wd_cyc;
  logic [31:0] last_reg3 = 32'd0;

  core_run_sequencer #(
    .CYCLE_W         (16),
    .CORE_RST_CYCLES (4),
    .TIMEOUT         (100)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start_btn    (start_btn),
    .core_done    (core_done),
    .core_reg3    (core_reg3),
    .core_pc      (core_pc),
    .core_reset   (core_reset),
    .core_run     (core_run),
    .result_reg3  (result_reg3),
    .result_pc    (result_pc),
    .run_cycles   (run_cycles),
    .result_valid (result_valid),
    .busy         (busy),
    .timeout_flag (timeout_flag),
    .seq_state    (seq_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Press the button, play the core (done on WAIT_DONE cycle done_at, 0 = never)
  // and follow the run until HOLD after a capture, or ERROR.
  task automatic run_prog(input logic [31:0] reg3, input logic [31:0] pc, input int done_at,
                          input bit glitch, input bit exp_cap, input int limit);
    int   cyc;
    int   wdc;
    int   ecyc;
    bit   seen_cap;
    bit   fin;
    exp_t e;
    cyc = 0; wdc = 0; seen_cap = 1'b0; fin = 1'b0;
    n_rst = 0; n_start = 0; run_bad = 0;
    if (exp_cap) begin
      ecyc = done_at - 1;
      if (ecyc > 65535) ecyc = 65535;
      e.reg3 = reg3; e.pc = pc; e.cyc = 16'(ecyc);
      exp_q.push_back(e);
    end
    core_reg3 = 32'hBAD0_0000;
    core_pc   = 32'hBAD0_0001;
    start_btn = 1'b1;
    while (!fin && cyc < limit) begin
      @(negedge clock);
      cyc++;
      if (cyc == 10) start_btn = 1'b0;
      case (seq_state)
        3'd1: begin
          n_rst++;
          if (core_reset !== 1'b1 || core_run !== 1'b0) run_bad++;
          if (n_rst == 1) begin
            chk("valid_drop_in_core_rst", result_valid, 1'b0);
            chk("reg3_kept_in_core_rst", result_reg3, last_reg3);
          end
        end
        3'd2: n_start++;
        3'd3: begin
          wdc++;
          if (core_run !== 1'b1 || core_reset !== 1'b0) run_bad++;
          if (glitch) begin
            if (wdc == 6 || wdc == 8) start_btn = 1'b1;
            if (wdc == 7 || wdc == 9) start_btn = 1'b0;
          end
          if (wdc == done_at) begin
            core_done = 1'b1;
            core_reg3 = reg3;
            core_pc   = pc;
          end
        end
        3'd4: begin
          seen_cap  = 1'b1;
          core_done = 1'b0;
        end
        3'd5: if (seen_cap) fin = 1'b1;
        3'd6: if (wdc > 0) fin = 1'b1;
        default: ;
      endcase
    end
    chk("run_reached_end_state", fin, 1'b1);
    wd_cyc = wdc;
  endtask

  // Compare HOLD results against the queued expectation, then confirm they
  // stay put while the core's outputs move.
  task automatic check_hold();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_has_entry", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      chk("result_reg3", result_reg3, e.reg3);
      chk("result_pc", result_pc, e.pc);
      chk("run_cycles", run_cycles, e.cyc);
      chk("hold_state", seq_state, 3'd5);
      chk("hold_valid", result_valid, 1'b1);
      chk("hold_core_reset", core_reset, 1'b0);
      chk("hold_core_run", core_run, 1'b0);
      chk("hold_busy", busy, 1'b0);
      chk("hold_timeout_flag", timeout_flag, 1'b0);
      chk("core_rst_cycles", n_rst, 4);
      chk("start_count", n_start, 1);
      chk("run_drive_errors", run_bad, 0);
      core_reg3 = ~e.reg3;
      core_pc   = ~e.pc;
      tick(5);
      chk("hold_reg3_stable", result_reg3, e.reg3);
      chk("hold_pc_stable", result_pc, e.pc);
      chk("hold_single_run", seq_state, 3'd5);
      last_reg3 = e.reg3;
    end
  endtask

  initial begin
    reset = 1'b1; start_btn = 1'b0; core_done = 1'b0;
    core_reg3 = 32'd0; core_pc = 32'd0;
    tick(3);
    reset = 1'b0;
    tick(2);
    chk("reset_state", seq_state, 3'd0);
    chk("reset_core_reset", core_reset, 1'b1);
    chk("reset_core_run", core_run, 1'b0);
    chk("reset_reg3", result_reg3, 32'd0);
    chk("reset_pc", result_pc, 32'd0);
    chk("reset_cycles", run_cycles, 16'd0);
    chk("reset_valid", result_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_timeout", timeout_flag, 1'b0);

    // First run: done on the 37th WAIT_DONE cycle.
    run_prog(32'h0000_002A, 32'h0000_0044, 37, 1'b0, 1'b1, 200);
    check_hold();

    // Second press from HOLD with new values.
    run_prog(32'h1234_5678, 32'h0000_0100, 5, 1'b0, 1'b1, 200);
    check_hold();

    // Button bounces during WAIT_DONE must not disturb the run.
    run_prog(32'hCAFE_F00D, 32'h0000_0200, 20, 1'b1, 1'b1, 200);
    chk("glitch_wait_cycles", wd_cyc, 20);
    check_hold();

`ifdef CORE_WATCHDOG_EN
    run_prog(32'h0, 32'h0, 0, 1'b0, 1'b0, 400);
    chk("wd_wait_cycles", wd_cyc, 101);
    chk("wd_state", seq_state, 3'd6);
    chk("wd_timeout_flag", timeout_flag, 1'b1);
    chk("wd_core_reset", core_reset, 1'b1);
    chk("wd_core_run", core_run, 1'b0);
    chk("wd_valid", result_valid, 1'b0);
    chk("wd_busy", busy, 1'b0);
    chk("wd_reg3_kept", result_reg3, last_reg3);
    run_prog(32'h0000_0777, 32'h0000_0300, 101, 1'b0, 1'b1, 400);
    check_hold();
`else
    run_prog(32'h0000_0555, 32'h0000_0400, 65540, 1'b0, 1'b1, 70000);
    chk("sat_wait_cycles", wd_cyc, 65540);
    check_hold();
`endif

    // Asynchronous reset in the middle of WAIT_DONE.
    start_btn = 1'b1;
    tick(3);
    start_btn = 1'b0;
    begin
      int guard;
      guard = 0;
      while (seq_state !== 3'd3 && guard < 50) begin
        tick(1);
        guard++;
      end
      chk("reached_wait_done", seq_state, 3'd3);
    end
    tick(5);
    #2;
    reset = 1'b1;
    #1;
    chk("async_core_reset", core_reset, 1'b1);
    chk("async_core_run", core_run, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_state", seq_state, 3'd0);
    chk("async_valid", result_valid, 1'b0);
    core_done = 1'b1;
    core_reg3 = 32'hDEAD_BEEF;
    tick(2);
    reset = 1'b0;
    tick(4);
    core_done = 1'b0;
    chk("post_reset_state", seq_state, 3'd0);
    chk("post_reset_no_capture", result_reg3, 32'd0);
    chk("post_reset_valid", result_valid, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
